// File: rtl/display_pkg.sv
// Shared constants and types for the X/Y seven-segment display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic [0:0] {
    StXPage = 1'b0,
    StYPage = 1'b1
  } page_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/xy_display_scanner.sv
// Multiplexed 8-digit hex display alternating pages between the X and Y result buses.
// Each value is snapshotted at frame boundaries so a frame never shows mixed digits.
module xy_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned PAGE_FRAMES = 200
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        Freeze,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        PageY
);

  localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FrmW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam logic [DivW-1:0] DivLast   = DivW'(REFRESH_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast   = FrmW'(PAGE_FRAMES - 1);
  localparam logic [2:0]      DigitLast = 3'(NUM_DIGITS - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      digit_q, digit_d;
  logic [FrmW-1:0] frame_q, frame_d;
  page_e           page_q, page_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            page_y_q, page_y_d;

  logic       digit_tick;
  logic       frame_end;
  logic       page_done;
  logic       page_is_y;
  logic [3:0] nibble;
  logic [6:0] seg_code;

  assign digit_tick = (div_q == DivLast);
  assign frame_end  = digit_tick && (digit_q == DigitLast);
  assign page_done  = (frame_q == FrmLast);

  // Page FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      page_q <= StXPage;
    end else begin
      page_q <= page_d;
    end
  end

  // Page FSM: next state; Freeze only matters once the page has run its full length
  always_comb begin
    page_d = page_q;
    if (frame_end && page_done && !Freeze) begin
      unique case (page_q)
        StXPage: page_d = StYPage;
        StYPage: page_d = StXPage;
        default: page_d = StXPage;
      endcase
    end
  end

  // Page FSM: outputs
  always_comb begin
    page_is_y = (page_q == StYPage);
  end

  always_comb begin
    div_d    = digit_tick ? '0 : div_q + 1'b1;
    digit_d  = digit_tick ? digit_q + 1'b1 : digit_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    if (frame_end) begin
      if (page_done) begin
        // Holding at the last frame lets the page flip at the first boundary after unfreeze.
        frame_d = Freeze ? frame_q : '0;
      end else begin
        frame_d = frame_q + 1'b1;
      end
      shadow_d = (page_d == StYPage) ? Y : X;
    end
  end

  assign nibble = shadow_q[{digit_q, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nibble),
    .seg_o    (seg_code)
  );

  always_comb begin
    an_d     = ~(8'b1 << digit_q);
    seg_d    = seg_code;
    dp_d     = ~(page_is_y && (digit_q == DigitLast));
    page_y_d = page_is_y;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q    <= '0;
      digit_q  <= '0;
      frame_q  <= '0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      page_y_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      page_y_q <= page_y_d;
    end
  end

  assign An    = an_q;
  assign Seg   = seg_q;
  assign Dp    = dp_q;
  assign PageY = page_y_q;

endmodule

// File: tb/tb_xy_display_scanner.sv
// Self-checking bench for xy_display_scanner: directed scenarios plus a randomized run,
// all compared cycle by cycle against a frame-position reference model.
module tb_xy_display_scanner;

  localparam int unsigned RD    = 4;
  localparam int unsigned PF    = 2;
  localparam int unsigned FRAME = 8 * RD;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Freeze = 1'b0;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        PageY;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] exp_f2 [8] = '{7'h0E, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};

  // Reference model: position within the frame, frames shown on this page, page, snapshot
  int          m_pos    = 0;
  int          m_frames = 0;
  bit          m_page   = 1'b0;
  logic [31:0] m_shadow = '0;

  xy_display_scanner #(
    .REFRESH_DIV (RD),
    .PAGE_FRAMES (PF)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .X      (X),
    .Y      (Y),
    .Freeze (Freeze),
    .An     (An),
    .Seg    (Seg),
    .Dp     (Dp),
    .PageY  (PageY)
  );

  initial forever #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  // Advance one clock, predicting the registered outputs from the pre-edge model state.
  task automatic step();
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    logic       ep;
    int         d;
    if (Reset) begin
      ea = 8'hFF; es = 7'h7F; ed = 1'b1; ep = 1'b0;
      m_pos = 0; m_frames = 0; m_page = 1'b0; m_shadow = '0;
      cyc = 0;
    end else begin
      d  = m_pos / RD;
      ea = ~(8'h01 << d);
      es = hex_tbl[(m_shadow >> (4 * d)) & 32'hF];
      ed = !(m_page && d == 7);
      ep = m_page;
      if (m_pos == FRAME - 1) begin
        if (m_frames == PF - 1) begin
          if (!Freeze) begin
            m_page   = !m_page;
            m_frames = 0;
          end
        end else begin
          m_frames++;
        end
        m_shadow = m_page ? Y : X;
      end
      m_pos = (m_pos + 1) % FRAME;
      cyc++;
    end
    @(posedge Clk);
    #1;
    check("an", An, ea);
    check("seg", Seg, es);
    check("dp", Dp, ed);
    check("pagey", PageY, ep);
  endtask

  initial begin
    int  found;

    // 1: reset held for three cycles with noise on the data buses
    X = $urandom; Y = $urandom; Reset = 1'b1;
    repeat (3) step();

    // 2/3: first frame is zeros, second shows X, Y page appears at cycle 65
    X = 32'h0123ABCF; Y = 32'h88888888; Reset = 1'b0;
    step();
    check("first_an", An, 8'hFE);
    check("first_seg", Seg, 7'h40);
    while (cyc < 64) begin
      step();
      if (cyc >= 33) begin
        check("frame2_seg", Seg, exp_f2[(cyc - 33) / 4]);
        check("frame2_dp", Dp, 1'b1);
      end
    end
    step();
    check("ypage_start", PageY, 1'b1);
    check("ypage_seg", Seg, 7'h00);
    while (cyc < 129) step();
    check("xpage_return", PageY, 1'b0);

    // 4: mid-frame change of X is not visible until the next boundary
    Reset = 1'b1; step();
    Reset = 1'b0; X = 32'h11111111; Y = 32'h0;
    while (cyc < 44) step();
    X = 32'h22222222; Y = 32'h22222222;
    while (cyc < 64) begin
      step();
      check("midframe_hold", Seg, 7'h79);
    end
    while (cyc < 96) begin
      step();
      check("next_frame", Seg, 7'h24);
    end

    // 5: Freeze across the page boundary, then release mid-frame
    Reset = 1'b1; step();
    Reset = 1'b0; Freeze = 1'b1;
    while (cyc < 200) begin
      step();
      check("frozen_page", PageY, 1'b0);
    end
    Freeze = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (PageY === 1'b1) found = cyc;
    end
    check("unfreeze_cycle", found, 225);

    // 6: single-cycle reset in the middle of the Y page
    repeat (16) step();
    Reset = 1'b1; step();
    check("midreset_an", An, 8'hFF);
    check("midreset_page", PageY, 1'b0);
    Reset = 1'b0; step();
    check("restart_an", An, 8'hFE);
    check("restart_seg", Seg, 7'h40);

    // Randomized run: bus changes, Freeze toggles and occasional resets
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) X = $urandom;
      if ($urandom_range(0, 7) == 0) Y = $urandom;
      if ($urandom_range(0, 15) == 0) Freeze = ~Freeze;
      Reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
